sat_addsub_acc: RTL and testbench
=================================

# sat_addsub_acc

Parametrised, registered saturating adder/subtractor with an internal accumulator, a valid/ready handshake on both sides, and a sticky overflow flag. It extends the combinational 8-bit saturating add/sub in four ways: configurable width, a selectable wrap/saturate mode, accumulate operations, and backpressure. It sits in the datapath between an operand source (register file or sample stream) and a downstream consumer that may stall.

## Interface
- WIDTH, 8: operand/result width in bits, two's complement; legal range 4..32.
- CIN_SHIFT, 4: weight of `cin`, which adds 2^CIN_SHIFT to the sum; must be < WIDTH-1.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  signed operand A; ignored for accumulate ops.
- b  in  WIDTH  signed operand B.
- op  in  2  00: a+b; 01: a-b; 10: acc+b; 11: acc-b.
- cin  in  1  adds 2^CIN_SHIFT to the sum.
- sat_en  in  1  1 = saturate, 0 = wrap; sampled with the beat.
- acc_clr  in  1  clears the accumulator; sampled on every cycle, not only on handshake cycles.
- sticky_clr  in  1  clears `ovf_sticky`.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  signed result.
- ovf  out  1  range overflow of the current `result`, flagged in both modes.
- ovf_sticky  out  1  set by any accepted beat whose `ovf` is 1.
- acc  out  WIDTH  current accumulator value.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = !rst && (!out_valid || out_ready)`, a single-entry output register with pass-through on pop.
- Arithmetic on an accepted beat, at WIDTH+2 bits signed:
  - x = op[1] ? acc_eff : sext(a).
  - y = op[0] ? -sext(b) : sext(b).
  - s = x + y + (cin ? 2^CIN_SHIFT : 0).
  - The width is sufficient: worst case is (2^(W-1)-1) + 2^(W-1) + 2^CIN_SHIFT, so no overflow is possible in the extended sum.
- Range check with MAX = 2^(W-1)-1 and MIN = -2^(W-1):
  - s > MAX: ovf=1; result = MAX if sat_en, else s[W-1:0].
  - s < MIN: ovf=1; result = MIN if sat_en, else s[W-1:0].
  - Otherwise ovf=0 and result = s[W-1:0].
- Accumulator:
  - acc_eff = acc_clr ? 0 : acc.
  - On an accepted op[1]=1 beat: acc <= result, i.e. the saturated or wrapped value.
  - acc_clr with no accepted acc op: acc <= 0.
  - Accepted op[1]=0 beats do not modify acc.
- Output register:
  - On accept: result, ovf <= computed values and out_valid <= 1.
  - On `out_valid && out_ready` with no accept: out_valid <= 0.
  - result and ovf hold their values while out_valid && !out_ready.
- Sticky flag: next = (ovf_sticky && !sticky_clr) || (accept && ovf_new). A set in the same cycle as sticky_clr wins.

## Timing
- Latency 1: a beat accepted at edge N appears on result/out_valid after edge N.
- Throughput 1 beat/cycle while out_ready=1, including back-to-back accumulate ops. There is no hazard because acc updates at the same edge the beat is accepted.
- Reset values (synchronous, at the first edge with rst=1):
  - out_valid=0, result=0, ovf=0, ovf_sticky=0, acc=0.
  - in_ready is 0 combinationally while rst=1.
- Reset mid-operation: a pending unconsumed result is dropped and not presented after reset. A beat offered during rst is not accepted.
- Beats are never lost or duplicated under any out_ready pattern.

## Test plan
All scenarios use WIDTH=8 and CIN_SHIFT=4.
- Saturation, positive: a=100, b=50, op=00, sat_en=1 -> result=127 (0x7F), ovf=1, ovf_sticky=1 from the next cycle. Then sticky_clr=1 with a clean beat a=1, b=1 -> result=2, ovf=0, ovf_sticky=0.
- Subtract at the extremes: a=-128, b=127, op=01.
  - sat_en=1 -> result=-128 (0x80), ovf=1.
  - sat_en=0 -> result=0x01, ovf=1.
  - a=0, b=-128, op=01, sat_en=1 -> s=128, so result=127, ovf=1.
- Carry-in weight: a=10, b=5, cin=1, op=00 -> result=31 (0x1F), ovf=0.
- Accumulate: acc_clr pulse, then three back-to-back beats of op=10, b=100, sat_en=1 -> results 100, 127, 127; ovf 0, 1, 1; acc=127. Follow with op=11, b=27 -> result=100, acc=100. Then acc_clr together with op=10, b=5 -> result=5, acc=5.
- Backpressure: out_ready=0 after the first result -> in_ready=0, result stable for 5 cycles, second beat not accepted. Raise out_ready -> second beat accepted in the same cycle the first is popped, and results arrive in order.
- Reset mid-stream: rst=1 while out_valid=1 and acc=50 -> next cycle out_valid=0, acc=0, ovf_sticky=0, result=0; in_ready=0 throughout rst.

Source files
------------

// File: rtl/sat_addsub_acc.sv
// sat_addsub_acc: registered saturating/wrapping add-subtract with an
// internal accumulator, valid/ready handshakes on both sides and a sticky
// overflow flag. A single output register holds the last result; it can be
// refilled in the same cycle it is popped.
module sat_addsub_acc #(
    parameter int WIDTH     = 8,
    parameter int CIN_SHIFT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             cin_i,
    input  logic             sat_en_i,
    input  logic             acc_clr_i,
    input  logic             sticky_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             ovf_sticky_o,
    output logic [WIDTH-1:0] acc_o
);

    // Two guard bits are enough to hold the worst-case sum without overflow.
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MAX_EXT = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_EXT = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] CIN_EXT = (EW)'(1) << CIN_SHIFT;
    localparam logic [WIDTH-1:0]     MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic                 accept;
    logic [WIDTH-1:0]     acc_eff;
    logic signed [EW-1:0] op_x;
    logic signed [EW-1:0] b_ext;
    logic signed [EW-1:0] op_y;
    logic signed [EW-1:0] sum;
    logic                 ovf_new;
    logic [WIDTH-1:0]     res_new;

    assign in_ready_o   = !rst_i && (!out_valid_q || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = out_valid_q;
    assign result_o     = result_q;
    assign ovf_o        = ovf_q;
    assign ovf_sticky_o = sticky_q;
    assign acc_o        = acc_q;

    // Extended-width arithmetic followed by range check and saturate/wrap.
    always_comb begin
        acc_eff = acc_clr_i ? '0 : acc_q;
        op_x    = op_i[1] ? {{2{acc_eff[WIDTH-1]}}, acc_eff}
                          : {{2{a_i[WIDTH-1]}}, a_i};
        b_ext   = {{2{b_i[WIDTH-1]}}, b_i};
        op_y    = op_i[0] ? -b_ext : b_ext;
        sum     = op_x + op_y + (cin_i ? CIN_EXT : '0);
        ovf_new = 1'b0;
        res_new = sum[WIDTH-1:0];
        if (sum > MAX_EXT) begin
            ovf_new = 1'b1;
            if (sat_en_i) res_new = MAX_W;
        end else if (sum < MIN_EXT) begin
            ovf_new = 1'b1;
            if (sat_en_i) res_new = MIN_W;
        end
    end

    // Next-state for the output register, accumulator and sticky flag.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        sticky_d    = (sticky_q && !sticky_clr_i) || (accept && ovf_new);
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_new;
            ovf_d       = ovf_new;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept && op_i[1]) begin
            acc_d = res_new;
        end else if (acc_clr_i) begin
            acc_d = '0;
        end
    end

    // State registers with synchronous reset; reset drops any pending result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_sat_addsub_acc.sv
// Directed testbench for sat_addsub_acc (WIDTH=8, CIN_SHIFT=4) with
// hand-computed expected values.
module tb_sat_addsub_acc;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       cin;
    logic       satEn;
    logic       accClr;
    logic       stickyClr;
    logic       outValid;
    logic       outReady;
    logic [7:0] result;
    logic       ovf;
    logic       ovfSticky;
    logic [7:0] acc;

    int checkCount = 0;
    int failCount  = 0;

    sat_addsub_acc #(.WIDTH(8), .CIN_SHIFT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (inValid),
        .in_ready_o   (inReady),
        .a_i          (a),
        .b_i          (b),
        .op_i         (op),
        .cin_i        (cin),
        .sat_en_i     (satEn),
        .acc_clr_i    (accClr),
        .sticky_clr_i (stickyClr),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .result_o     (result),
        .ovf_o        (ovf),
        .ovf_sticky_o (ovfSticky),
        .acc_o        (acc)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one beat's worth of inputs; takes effect at the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [1:0] opv, input logic cv, input logic sv,
                                 input logic clr, input logic sclr);
        inValid   = v;
        a         = av;
        b         = bv;
        op        = opv;
        cin       = cv;
        satEn     = sv;
        accClr    = clr;
        stickyClr = sclr;
    endtask

    // Advances one clock and lands 1 ns after the edge for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("in_ready_in_reset", inReady, 0);
        step();
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_sticky", ovfSticky, 0);
        checkOutput("rst_acc", acc, 0);
        rst = 1'b0;
        step();

        // Positive saturation, then sticky clear alongside a clean beat.
        applyStimulus(1'b1, 8'd100, 8'd50, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("in_ready_idle", inReady, 1);
        step();
        checkOutput("satpos_result", result, 8'h7F);
        checkOutput("satpos_ovf", ovf, 1);
        checkOutput("satpos_valid", outValid, 1);
        checkOutput("satpos_sticky", ovfSticky, 1);
        applyStimulus(1'b1, 8'd1, 8'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput("clean_result", result, 8'd2);
        checkOutput("clean_ovf", ovf, 0);
        checkOutput("sticky_cleared", ovfSticky, 0);

        // Subtract at the extremes, saturate and wrap.
        applyStimulus(1'b1, 8'h80, 8'd127, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("subneg_sat_result", result, 8'h80);
        checkOutput("subneg_sat_ovf", ovf, 1);
        applyStimulus(1'b1, 8'h80, 8'd127, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("subneg_wrap_result", result, 8'h01);
        checkOutput("subneg_wrap_ovf", ovf, 1);
        applyStimulus(1'b1, 8'd0, 8'h80, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("subpos_sat_result", result, 8'h7F);
        checkOutput("subpos_sat_ovf", ovf, 1);

        // Carry-in weight of 16.
        applyStimulus(1'b1, 8'd10, 8'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("cin_result", result, 8'h1F);
        checkOutput("cin_ovf", ovf, 0);

        // Accumulator: clear pulse, three back-to-back adds, subtract, clear+add.
        applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("accclr_acc", acc, 0);
        checkOutput("accclr_drained", outValid, 0);
        applyStimulus(1'b1, 8'd0, 8'd100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("acc1_result", result, 8'd100);
        checkOutput("acc1_ovf", ovf, 0);
        checkOutput("acc1_acc", acc, 8'd100);
        step();
        checkOutput("acc2_result", result, 8'd127);
        checkOutput("acc2_ovf", ovf, 1);
        step();
        checkOutput("acc3_result", result, 8'd127);
        checkOutput("acc3_ovf", ovf, 1);
        checkOutput("acc3_acc", acc, 8'd127);
        applyStimulus(1'b1, 8'd0, 8'd27, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("accsub_result", result, 8'd100);
        checkOutput("accsub_acc", acc, 8'd100);
        applyStimulus(1'b1, 8'd0, 8'd5, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("accclradd_result", result, 8'd5);
        checkOutput("accclradd_acc", acc, 8'd5);
        applyStimulus(1'b1, 8'd7, 8'd7, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("plainop_keeps_acc", acc, 8'd5);
        checkOutput("plainop_result", result, 8'd14);

        // Backpressure: the second beat waits until the first is popped.
        applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outReady = 1'b0;
        applyStimulus(1'b1, 8'd3, 8'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("bp_first_result", result, 8'd7);
        applyStimulus(1'b1, 8'd20, 8'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready_low", inReady, 0);
            step();
            checkOutput("bp_result_hold", result, 8'd7);
            checkOutput("bp_valid_hold", outValid, 1);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_in_ready_pop", inReady, 1);
        step();
        checkOutput("bp_second_result", result, 8'd21);
        checkOutput("bp_second_valid", outValid, 1);
        applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("bp_drained", outValid, 0);

        // Reset mid-stream with a pending result and acc=50.
        outReady = 1'b0;
        applyStimulus(1'b1, 8'd0, 8'd50, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("pre_rst_acc", acc, 8'd50);
        checkOutput("pre_rst_valid", outValid, 1);
        checkOutput("pre_rst_sticky", ovfSticky, 1);
        rst = 1'b1;
        applyStimulus(1'b1, 8'd9, 8'd9, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        outReady = 1'b1;
        #1;
        checkOutput("midrst_in_ready", inReady, 0);
        step();
        checkOutput("midrst_valid", outValid, 0);
        checkOutput("midrst_acc", acc, 0);
        checkOutput("midrst_sticky", ovfSticky, 0);
        checkOutput("midrst_result", result, 0);
        checkOutput("midrst_in_ready2", inReady, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("postrst_no_beat", outValid, 0);
        checkOutput("postrst_result", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
